// File: rtl/cpu_pkg.sv
// Purpose: shared register-file widths and the write-back entry layout.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package cpu_pkg;

    localparam int REG_AW = 5;
    localparam int REG_DW = 16;

    typedef struct packed {
        logic [REG_AW-1:0] addr;
        logic [REG_DW-1:0] data;
    } wb_entry_t;

endpackage

// File: rtl/fifo.sv
// Purpose: generic circular FIFO (head/tail/count) that also exposes its storage for lookups.
// Latency: a push at edge N is visible at pop_dat from cycle N+1.
// Backpressure: push_rdy drops when full; pop only when pop_vld && pop_rdy.
module fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             push_vld,
    input  logic [WIDTH-1:0]                 push_dat,
    output logic                             push_rdy,
    output logic                             pop_vld,
    input  logic                             pop_rdy,
    output logic [WIDTH-1:0]                 pop_dat,
    output logic [$clog2(DEPTH):0]           count,
    output logic [$clog2(DEPTH)-1:0]         head,
    output logic [DEPTH-1:0][WIDTH-1:0]      entries
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [DEPTH-1:0][WIDTH-1:0] mem_q, mem_d;
    logic [PW-1:0]               head_q, head_d;
    logic [PW-1:0]               tail_q, tail_d;
    logic [CW-1:0]               count_q, count_d;
    logic                        push_fire;
    logic                        pop_fire;

    assign push_rdy  = (count_q != CW'(DEPTH));
    assign pop_vld   = (count_q != '0);
    assign push_fire = push_vld && push_rdy;
    assign pop_fire  = pop_vld && pop_rdy;

    always_comb begin
        mem_d   = mem_q;
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (push_fire) begin
            mem_d[tail_q] = push_dat;
            tail_d        = tail_q + PW'(1);
        end
        if (pop_fire) begin
            head_d = head_q + PW'(1);
        end
        case ({push_fire, pop_fire})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // Storage is not reset: unoccupied slots are never observed.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
        if (reset) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    assign pop_dat = pop_vld ? mem_q[head_q] : '0;
    assign count   = count_q;
    assign head    = head_q;
    assign entries = mem_q;

endmodule

// File: rtl/wb_match.sv
// Purpose: youngest-match search of queued write-backs for one read port; data forwarding only with WB_QUEUE_FWD_EN.
// Latency: combinational.
// Backpressure: none (pure lookup over stored entries).
module wb_match #(
    parameter int DEPTH = 4,
    parameter int AW    = 5,
    parameter int DW    = 16
) (
    input  logic [DEPTH-1:0][AW+DW-1:0] entries,
    input  logic [$clog2(DEPTH)-1:0]    head,
    input  logic [$clog2(DEPTH):0]      count,
    input  logic [AW-1:0]               rd_addr,
    output logic                        pend,
    output logic [DW-1:0]               fwd
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam int EW = AW + DW;

    // Walk oldest to youngest so the last hit is the youngest entry.
    always_comb begin
        logic [PW-1:0] idx;
        pend = 1'b0;
        idx  = head;
`ifdef WB_QUEUE_FWD_EN
        fwd  = '0;
`endif
        for (int i = 0; i < DEPTH; i++) begin
            idx = head + PW'(i);
            if ((CW'(i) < count) && (rd_addr != '0) && (entries[idx][EW-1:DW] == rd_addr)) begin
                pend = 1'b1;
`ifdef WB_QUEUE_FWD_EN
                fwd  = entries[idx][DW-1:0];
`endif
            end
        end
    end

`ifndef WB_QUEUE_FWD_EN
    logic unused_data;
    assign fwd         = '0;
    assign unused_data = ^entries;
`endif

endmodule

// File: rtl/wb_queue.sv
// Purpose: write-back queue between producers and the register file, with pending/forward lookup (WB_QUEUE_FWD_EN).
// Latency: push at edge N drives write_enable in cycle N+1.
// Backpressure: in_ready low only when full; rf_stall holds the head in place.
module wb_queue
    import cpu_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int AW    = REG_AW,
    parameter int DW    = REG_DW
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [AW-1:0]            in_addr,
    input  logic [DW-1:0]            in_data,
    input  logic                     rf_stall,
    output logic                     write_enable,
    output logic [AW-1:0]            write_address,
    output logic [DW:0]              write_data,
    input  logic [AW-1:0]            read_address_one,
    input  logic [AW-1:0]            read_address_two,
    output logic                     pend_one,
    output logic                     pend_two,
    output logic [DW-1:0]            fwd_one,
    output logic [DW-1:0]            fwd_two,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PW = $clog2(DEPTH);
    localparam int EW = AW + DW;

    logic                        push_vld;
    logic [EW-1:0]               push_dat;
    logic                        head_vld;
    logic                        head_rdy;
    logic [EW-1:0]               head_dat;
    logic [PW-1:0]               head;
    logic [DEPTH-1:0][EW-1:0]    entries;

    // r0 writes complete the handshake but never occupy a slot.
    assign push_vld = in_valid && (in_addr != '0);
    assign push_dat = {in_addr, in_data};
    assign head_rdy = !rf_stall;

    fifo #(
        .DEPTH (DEPTH),
        .WIDTH (EW)
    ) u_fifo (
        .clk      (clk),
        .reset    (reset),
        .push_vld (push_vld),
        .push_dat (push_dat),
        .push_rdy (in_ready),
        .pop_vld  (head_vld),
        .pop_rdy  (head_rdy),
        .pop_dat  (head_dat),
        .count    (count),
        .head     (head),
        .entries  (entries)
    );

    assign write_enable  = head_vld && head_rdy;
    assign write_address = head_dat[EW-1:DW];
    assign write_data    = {1'b0, head_dat[DW-1:0]};

    wb_match #(
        .DEPTH (DEPTH),
        .AW    (AW),
        .DW    (DW)
    ) u_match_one (
        .entries (entries),
        .head    (head),
        .count   (count),
        .rd_addr (read_address_one),
        .pend    (pend_one),
        .fwd     (fwd_one)
    );

    wb_match #(
        .DEPTH (DEPTH),
        .AW    (AW),
        .DW    (DW)
    ) u_match_two (
        .entries (entries),
        .head    (head),
        .count   (count),
        .rd_addr (read_address_two),
        .pend    (pend_two),
        .fwd     (fwd_two)
    );

endmodule

// File: doc/wb_queue.md
WB_QUEUE -- requirements
Module: wb_queue

Interface
REQ-001 Parameter DEPTH, default 4, number of queued write-back entries; the value SHALL be a power of two, 2..16.
REQ-002 Parameter AW, default 5, register address width.
REQ-003 Parameter DW, default 16, register data width.
REQ-004 clk  input  1  sole clock; all state SHALL update on posedge clk.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 in_valid  input  1  producer presents a write-back result.
REQ-007 in_ready  output  1  queue can accept a result.
REQ-008 in_addr  input  AW  destination register.
REQ-009 in_data  input  DW  result value.
REQ-010 rf_stall  input  1  register file cannot accept a write this cycle.
REQ-011 write_enable  output  1  register-file write strobe.
REQ-012 write_address  output  AW  register-file write address.
REQ-013 write_data  output  DW+1  register-file write data; the MSB SHALL always be 0.
REQ-014 read_address_one, read_address_two  input  AW  addresses being read by decode.
REQ-015 pend_one, pend_two  output  1  a queued write targets the matching read address.
REQ-016 fwd_one, fwd_two  output  DW  value of the youngest queued write to that address.
REQ-017 count  output  $clog2(DEPTH)+1  number of occupied entries.

Function
REQ-018 Storage SHALL be a circular FIFO with head and tail pointers plus an occupancy counter.
REQ-019 in_ready SHALL equal (count != DEPTH); it SHALL NOT depend on a same-cycle pop.
REQ-020 Push occurs when in_valid && in_ready && in_addr != 0.
REQ-021 A handshake with in_addr == 0 SHALL complete and discard the data, because r0 is never written.
REQ-022 write_enable SHALL equal (count != 0) && !rf_stall, combinationally.
REQ-023 write_address and write_data SHALL show the head entry; when empty they SHALL be 0.
REQ-024 A pop occurs when write_enable is 1; the head SHALL advance at that clock edge.
REQ-025 Latency: an entry pushed into an empty queue at edge N SHALL drive write_enable during cycle N+1, so the register file writes on that cycle's falling edge.
REQ-026 A simultaneous push and pop SHALL leave count unchanged; the pointers SHALL wrap modulo DEPTH.
REQ-027 A stalled head (rf_stall high) SHALL hold indefinitely, with no reordering and no drop.
REQ-028 pend_x SHALL be 1 iff an occupied entry has an address equal to read_address_x and read_address_x != 0; the lookup SHALL be combinational.
REQ-029 fwd_x SHALL return the data of the youngest matching entry (closest to tail), and 0 when pend_x is 0.
REQ-030 The lookup SHALL cover stored entries only; an entry being pushed in the same cycle SHALL NOT be visible.

Reset
REQ-031 While reset is high at posedge clk, the block SHALL set the head and tail pointers and count to 0; entry contents are don't-care.
REQ-032 After reset: in_ready=1, write_enable=0, write_address=0, write_data=0, pend_one=pend_two=0, fwd_one=fwd_two=0, count=0.
REQ-033 Reset during operation SHALL flush all queued entries without issuing writes; a push or pop in the reset cycle SHALL be ignored.

Configuration
REQ-034 Macro WB_QUEUE_FWD_EN defined: fwd_one and fwd_two SHALL behave per REQ-029.
REQ-035 WB_QUEUE_FWD_EN undefined: fwd_one and fwd_two SHALL be tied to 0, no data-select logic SHALL be built, and pend_one and pend_two SHALL still function.

Structure
REQ-036 The shared package cpu_pkg SHALL hold REG_AW=5, REG_DW=16, and the typedef wb_entry_t {addr, data}.
REQ-037 Sub-module wb_match SHALL implement the youngest-match search; the block SHALL instantiate it once per read port.

Verification
REQ-038 Reset, then push (addr 3, data 0x00AA) with rf_stall=0 -> the next cycle shows write_enable=1, write_address=3, write_data=0x000AA, and count returns to 0.
REQ-039 Hold rf_stall=1 and push 4 entries -> in_ready=0 and count=4; a fifth push is refused; release the stall -> 4 writes drain in push order over 4 cycles.
REQ-040 Push (5,0x1111) then (5,0x2222) with a stall, read_address_one=5 -> pend_one=1 and fwd_one=0x2222; with the macro off, fwd_one=0.
REQ-041 Push with in_addr=0 -> handshake completes, count stays 0, and pend stays 0 for read address 0.
REQ-042 With the queue full and the stall released, push and pop in the same cycle -> push refused; count goes 4 to 3 and the pointers wrap correctly over 10 cycles.
REQ-043 Assert reset with 3 entries queued -> next cycle count=0, write_enable=0, pend=0, and no write issued.
